// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection.
// Forwards EX/MEM and MEM/WB results and flags load-use hazards.
module id_ex_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_REG  = 5,
  parameter int NB_IMM  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_rs_addr,
  input  logic [NB_REG-1:0]  i_rt_addr,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_IMM-1:0]  i_imm,
  input  logic               i_zero_ext,
  input  logic               i_alu_src,
  input  logic               i_reg_dst,
  input  logic [NB_OP-1:0]   i_alu_op,
  input  logic [4:0]         i_shamt,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_exmem_reg_write,
  input  logic [NB_REG-1:0]  i_exmem_rd,
  input  logic [NB_DATA-1:0] i_exmem_data,
  input  logic               i_memwb_reg_write,
  input  logic [NB_REG-1:0]  i_memwb_rd,
  input  logic [NB_DATA-1:0] i_memwb_data,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_op,
  output logic [4:0]         o_shamt,
  output logic [NB_DATA-1:0] o_store_data,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_load_use_stall
);

  typedef struct packed {
    logic               valid;
    logic [NB_REG-1:0]  rs_addr;
    logic [NB_REG-1:0]  rt_addr;
    logic [NB_DATA-1:0] rs_data;
    logic [NB_DATA-1:0] rt_data;
    logic [NB_DATA-1:0] imm;
    logic               alu_src;
    logic [NB_REG-1:0]  write_reg;
    logic [NB_OP-1:0]   op;
    logic [4:0]         shamt;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } ex_t;

  ex_t ex_q, ex_d, cap;
  logic [NB_DATA-1:0] fwd_a, fwd_b;
  logic lus;

  // Build the entry that a normal capture would load
  always_comb begin
    cap           = '0;
    cap.valid     = i_valid;
    cap.rs_addr   = i_rs_addr;
    cap.rt_addr   = i_rt_addr;
    cap.rs_data   = i_rs_data;
    cap.rt_data   = i_rt_data;
    cap.imm       = i_zero_ext
      ? {{(NB_DATA-NB_IMM){1'b0}}, i_imm}
      : {{(NB_DATA-NB_IMM){i_imm[NB_IMM-1]}}, i_imm};
    cap.alu_src   = i_alu_src;
    cap.write_reg = i_reg_dst ? i_rd_addr : i_rt_addr;
    cap.op        = i_alu_op;
    cap.shamt     = i_shamt;
    cap.reg_write = i_reg_write & i_valid;
    cap.mem_read  = i_mem_read & i_valid;
    cap.mem_write = i_mem_write & i_valid;
  end

  // Load in EX whose target is read by the instruction in ID
  always_comb begin
    lus = ex_q.valid & ex_q.mem_read &
          (ex_q.write_reg != '0) & i_valid & ~i_flush &
          ((ex_q.write_reg == i_rs_addr) |
           (ex_q.write_reg == i_rt_addr));
  end

  // Next entry: flush > stall > load-use bubble > capture
  always_comb begin
    ex_d = cap;
    if (i_flush)      ex_d = '0;
    else if (i_stall) ex_d = ex_q;
    else if (lus)     ex_d = '0;
  end

  // Pipeline register
  always_ff @(posedge i_clk) begin
    if (i_rst) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Bypass network; EX/MEM is newer so it wins, $0 is never bypassed
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (ex_q.rs_addr != '0 && i_exmem_reg_write &&
        i_exmem_rd == ex_q.rs_addr)
      fwd_a = i_exmem_data;
    else if (ex_q.rs_addr != '0 && i_memwb_reg_write &&
             i_memwb_rd == ex_q.rs_addr)
      fwd_a = i_memwb_data;
    fwd_b = ex_q.rt_data;
    if (ex_q.rt_addr != '0 && i_exmem_reg_write &&
        i_exmem_rd == ex_q.rt_addr)
      fwd_b = i_exmem_data;
    else if (ex_q.rt_addr != '0 && i_memwb_reg_write &&
             i_memwb_rd == ex_q.rt_addr)
      fwd_b = i_memwb_data;
  end

  assign o_valid          = ex_q.valid;
  assign o_datoA          = fwd_a;
  assign o_datoB          = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign o_store_data     = fwd_b;
  assign o_op             = ex_q.op;
  assign o_shamt          = ex_q.shamt;
  assign o_write_reg      = ex_q.write_reg;
  assign o_reg_write      = ex_q.reg_write;
  assign o_mem_read       = ex_q.mem_read;
  assign o_mem_write      = ex_q.mem_write;
  assign o_load_use_stall = lus;

endmodule
